alu_issue: RTL and testbench

- Issue/writeback front end for the 16-bit saturating ALU.
- Accepts one instruction word over a valid/ready handshake and reads operands from an internal 16x16 register file.
- Drives the ALU opcode/A/B/shift ports, captures the ALU result, then writes it back or resolves a branch.
- It is the producer side of the ALU interface: it generates exactly what the ALU consumes and consumes what the ALU produces.

---
 rtl/alu_issue_pkg.sv | 59 +++++
 rtl/alu_issue_regfile.sv | 42 ++++
 rtl/alu_issue.sv | 171 +++++++++++++++++
 tb/tb_alu_issue.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared definitions for the ALU issue/writeback front end.
// Holds the ALU opcode encodings, instruction field positions, the issue FSM
// state type and opcode classification helpers.
package alu_issue_pkg;

  // ALU opcode encodings (identical to the encodings the ALU decodes).
  localparam logic [7:0] AluNop  = 8'h00;
  localparam logic [7:0] AluAdd  = 8'h01;
  localparam logic [7:0] AluSub  = 8'h02;
  localparam logic [7:0] AluAnd  = 8'h03;
  localparam logic [7:0] AluOr   = 8'h04;
  localparam logic [7:0] AluXor  = 8'h05;
  localparam logic [7:0] AluShl  = 8'h06;
  localparam logic [7:0] AluShr  = 8'h07;
  localparam logic [7:0] AluRol  = 8'h08;
  localparam logic [7:0] AluRor  = 8'h09;
  localparam logic [7:0] AluAddI = 8'h11;
  localparam logic [7:0] AluSubI = 8'h12;
  localparam logic [7:0] AluAndI = 8'h13;
  localparam logic [7:0] AluOrI  = 8'h14;
  localparam logic [7:0] AluXorI = 8'h15;
  localparam logic [7:0] AluBez  = 8'h20;
  localparam logic [7:0] AluBnez = 8'h21;
  localparam logic [7:0] AluBeq  = 8'h22;

  // Instruction word layout: {opcode[31:24], rd[23:20], ra[19:16], field[15:0]}.
  localparam int unsigned OpLo  = 24;
  localparam int unsigned RdLo  = 20;
  localparam int unsigned RaLo  = 16;
  localparam int unsigned FldLo = 0;
  localparam int unsigned RbLo  = 0;   // register B index, field[3:0]
  localparam int unsigned ShLo  = 4;   // shift amount, field[8:4]
  localparam int unsigned OffLo = 4;   // branch offset, field[15:4]
  localparam int unsigned OffW  = 12;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2
  } state_e;

  function automatic logic is_imm(logic [7:0] op);
    return op inside {AluAddI, AluSubI, AluAndI, AluOrI, AluXorI};
  endfunction

  function automatic logic is_branch(logic [7:0] op);
    return op inside {AluBez, AluBnez, AluBeq};
  endfunction

  function automatic logic is_wb(logic [7:0] op);
    return is_imm(op) ||
           (op inside {AluAdd, AluSub, AluAnd, AluOr, AluXor, AluShl, AluShr, AluRol, AluRor});
  endfunction

  function automatic logic is_legal(logic [7:0] op);
    return is_wb(op) || is_branch(op) || (op == AluNop);
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile: 2**RA x N register file with r0 hardwired to zero.
// Ports: clk_i/rst_i (async active-high reset clears all entries),
//   raddr_a_i/rdata_a_o and raddr_b_i/rdata_b_o combinational operand reads,
//   dbg_addr_i/dbg_data_o combinational debug read,
//   we_i/waddr_i/wdata_i synchronous write port (writes to r0 are dropped).
module alu_issue_regfile #(
  parameter int unsigned N  = 16,
  parameter int unsigned RA = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [RA-1:0] raddr_a_i,
  output logic [N-1:0]  rdata_a_o,
  input  logic [RA-1:0] raddr_b_i,
  output logic [N-1:0]  rdata_b_o,
  input  logic [RA-1:0] dbg_addr_i,
  output logic [N-1:0]  dbg_data_o,
  input  logic          we_i,
  input  logic [RA-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i
);

  localparam int unsigned Depth = 2 ** RA;

  logic [N-1:0] mem_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // r0 is forced to zero on every read port regardless of storage contents.
  assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : mem_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: issue/writeback front end for the 16-bit saturating ALU.
// Ports: clk/rst (async active-high); instr_valid/instr_ready/instr accept one
//   instruction word; alu_opcode/alu_a/alu_b/alu_shift drive the ALU and alu_y
//   returns its result; wb_valid/wb_addr/wb_data report register writes;
//   br_valid/br_taken/br_offset report branch outcomes; illegal flags dropped
//   unknown opcodes; dbg_addr/dbg_data give a combinational register read.
// Sequence: IDLE (accept) -> EXEC (ALU inputs stable) -> WB (capture alu_y),
//   with result pulses appearing the cycle after WB.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned C  = 8,
  parameter int unsigned S  = 5,
  parameter int unsigned RA = 4,
  parameter int unsigned IW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [IW-1:0] instr,
  output logic [C-1:0]  alu_opcode,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [S-1:0]  alu_shift,
  input  logic [N-1:0]  alu_y,
  output logic          wb_valid,
  output logic [RA-1:0] wb_addr,
  output logic [N-1:0]  wb_data,
  output logic          br_valid,
  output logic          br_taken,
  output logic [11:0]   br_offset,
  output logic          illegal,
  input  logic [RA-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data
);

  state_e state_q, state_d;

  // Latched instruction: only the pieces needed after the accept edge.
  logic [C-1:0]    op_q;
  logic [RA-1:0]   rd_q;
  logic [OffW-1:0] off_q;

  logic [C-1:0]    alu_opcode_q;
  logic [N-1:0]    alu_a_q, alu_b_q;
  logic [S-1:0]    alu_shift_q;

  logic            wb_valid_q, br_valid_q, br_taken_q, illegal_q;
  logic [RA-1:0]   wb_addr_q;
  logic [N-1:0]    wb_data_q;
  logic [OffW-1:0] br_offset_q;

  logic [N-1:0]    rf_a, rf_b;
  logic            accept, rf_we;
  logic [C-1:0]    in_op;

  assign instr_ready = (state_q == StIdle);
  assign accept      = instr_valid && instr_ready;
  assign in_op       = instr[OpLo +: C];
  assign rf_we       = (state_q == StWb) && is_wb(op_q);

  alu_issue_regfile #(
    .N  (N),
    .RA (RA)
  ) u_regfile (
    .clk_i      (clk),
    .rst_i      (rst),
    .raddr_a_i  (instr[RaLo +: RA]),
    .rdata_a_o  (rf_a),
    .raddr_b_i  (instr[RbLo +: RA]),
    .rdata_b_o  (rf_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (alu_y)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU inputs are loaded at the accept edge straight from the incoming word
  // and the register file, so they are already stable for all of EXEC and
  // remain stable through WB when alu_y is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= '0;
      rd_q         <= '0;
      off_q        <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_shift_q  <= '0;
    end else if (accept) begin
      op_q         <= in_op;
      rd_q         <= instr[RdLo +: RA];
      off_q        <= instr[OffLo +: OffW];
      alu_opcode_q <= in_op;
      alu_a_q      <= rf_a;
      if (is_imm(in_op)) begin
        alu_b_q     <= instr[FldLo +: N];
        alu_shift_q <= '0;
      end else begin
        alu_b_q     <= rf_b;
        alu_shift_q <= instr[ShLo +: S];
      end
    end
  end

  // Result stage: pulses are registered at the WB edge and self-clear on the
  // following edge because the FSM is back in IDLE by then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      br_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      br_offset_q <= '0;
      illegal_q   <= 1'b0;
    end else if (state_q == StWb) begin
      wb_valid_q <= is_wb(op_q);
      br_valid_q <= is_branch(op_q);
      illegal_q  <= !is_legal(op_q);
      br_taken_q <= 1'b0;
      if (is_wb(op_q)) begin
        wb_addr_q <= rd_q;
        wb_data_q <= alu_y;
      end
      if (is_branch(op_q)) begin
        br_offset_q <= off_q;
        br_taken_q  <= (op_q == AluBnez) ? (alu_y != '0) : (alu_y == '0);
      end
    end else begin
      wb_valid_q <= 1'b0;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
      illegal_q  <= 1'b0;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_shift  = alu_shift_q;
  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign br_valid   = br_valid_q;
  assign br_taken   = br_taken_q;
  assign br_offset  = br_offset_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue. The bench plays
// the ALU by driving alu_y with hand-chosen results.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  alu_shift;
  logic [15:0] alu_y = '0;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        br_valid, br_taken;
  logic [11:0] br_offset;
  logic        illegal;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int total = 0;
  int bad   = 0;

  alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_shift   (alu_shift),
    .alu_y       (alu_y),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(logic [7:0] op, logic [3:0] rd, logic [3:0] ra,
                                     logic [15:0] fld);
    return {op, rd, ra, fld};
  endfunction

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a word in IDLE and return positioned in its EXEC cycle.
  task automatic issue(input logic [31:0] w);
    instr_valid = 1'b1;
    instr       = w;
    cyc();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", instr_ready); end
    total++; if ({wb_valid, br_valid, br_taken, illegal} !== 4'b0) begin bad++;
      $display("FAIL rst_pulses got=%b exp=0000", {wb_valid, br_valid, br_taken, illegal}); end
    total++; if ({alu_opcode, alu_a, alu_b, alu_shift} !== 45'h0) begin bad++;
      $display("FAIL rst_alu got=%h exp=0", {alu_opcode, alu_a, alu_b, alu_shift}); end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", instr_ready); end
    total++; if ({wb_addr, wb_data, br_offset} !== 32'h0) begin bad++;
      $display("FAIL post_rst_outs got=%h exp=0", {wb_addr, wb_data, br_offset}); end
    dbg_addr = 4'd7;
    #1;
    total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL rst_r7 got=%h exp=0000", dbg_data); end
  endtask

  task automatic test_imm_writeback();
    issue(mk(8'h11, 4'd1, 4'd0, 16'h0005));
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL imm_exec_ready got=%b exp=0", instr_ready); end
    total++; if (alu_opcode !== 8'h11) begin bad++; $display("FAIL imm_op got=%h exp=11", alu_opcode); end
    total++; if (alu_a !== 16'h0000) begin bad++; $display("FAIL imm_a got=%h exp=0000", alu_a); end
    total++; if (alu_b !== 16'h0005) begin bad++; $display("FAIL imm_b got=%h exp=0005", alu_b); end
    total++; if (alu_shift !== 5'd0) begin bad++; $display("FAIL imm_sh got=%h exp=0", alu_shift); end
    alu_y = 16'h0005;
    cyc();
    total++; if (instr_ready !== 1'b0 || wb_valid !== 1'b0) begin bad++;
      $display("FAIL imm_wbstate got=%b%b exp=00", instr_ready, wb_valid); end
    cyc();
    dbg_addr = 4'd1;
    #1;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL imm_wbv got=%b exp=1", wb_valid); end
    total++; if (wb_addr !== 4'd1) begin bad++; $display("FAIL imm_wba got=%h exp=1", wb_addr); end
    total++; if (wb_data !== 16'h0005) begin bad++; $display("FAIL imm_wbd got=%h exp=0005", wb_data); end
    total++; if (dbg_data !== 16'h0005) begin bad++; $display("FAIL imm_r1 got=%h exp=0005", dbg_data); end
    total++; if (br_valid !== 1'b0 || illegal !== 1'b0) begin bad++;
      $display("FAIL imm_excl got=%b%b exp=00", br_valid, illegal); end
    // r2 = 3 for the register-operand test.
    issue(mk(8'h11, 4'd2, 4'd0, 16'h0003));
    alu_y = 16'h0003;
    cyc();
    cyc();
    total++; if (wb_valid !== 1'b1 || wb_addr !== 4'd2) begin bad++;
      $display("FAIL imm2_wb got=%b/%h exp=1/2", wb_valid, wb_addr); end
    cyc();
    total++; if (wb_valid !== 1'b0 || wb_data !== 16'h0003) begin bad++;
      $display("FAIL imm2_hold got=%b/%h exp=0/0003", wb_valid, wb_data); end
  endtask

  task automatic test_reg_operands();
    issue(mk(8'h02, 4'd3, 4'd1, 16'h0072));
    total++; if (alu_a !== 16'd5) begin bad++; $display("FAIL sub_a got=%h exp=0005", alu_a); end
    total++; if (alu_b !== 16'd3) begin bad++; $display("FAIL sub_b got=%h exp=0003", alu_b); end
    total++; if (alu_shift !== 5'd7) begin bad++; $display("FAIL sub_sh got=%h exp=07", alu_shift); end
    alu_y = 16'hFFFE;
    cyc();
    cyc();
    dbg_addr = 4'd3;
    #1;
    total++; if (wb_valid !== 1'b1 || wb_addr !== 4'd3 || wb_data !== 16'hFFFE) begin bad++;
      $display("FAIL sub_wb got=%b/%h/%h exp=1/3/fffe", wb_valid, wb_addr, wb_data); end
    total++; if (dbg_data !== 16'hFFFE) begin bad++; $display("FAIL sub_r3 got=%h exp=fffe", dbg_data); end
  endtask

  task automatic test_r0_write();
    issue(mk(8'h11, 4'd0, 4'd0, 16'h0077));
    alu_y = 16'h0077;
    cyc();
    cyc();
    dbg_addr = 4'd0;
    #1;
    total++; if (wb_valid !== 1'b1 || wb_addr !== 4'd0 || wb_data !== 16'h0077) begin bad++;
      $display("FAIL r0_wb got=%b/%h/%h exp=1/0/0077", wb_valid, wb_addr, wb_data); end
    total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL r0_read got=%h exp=0000", dbg_data); end
  endtask

  task automatic test_branches();
    // BEZ ra=0, offset 0xFFF
    issue(mk(8'h20, 4'd0, 4'd0, 16'hFFF0));
    total++; if (alu_a !== 16'h0 || alu_b !== 16'h0) begin bad++;
      $display("FAIL bez_ops got=%h/%h exp=0000/0000", alu_a, alu_b); end
    alu_y = 16'h0000;
    cyc();
    cyc();
    total++; if ({br_valid, br_taken, wb_valid, illegal} !== 4'b1100) begin bad++;
      $display("FAIL bez_pulse got=%b exp=1100", {br_valid, br_taken, wb_valid, illegal}); end
    total++; if (br_offset !== 12'hFFF) begin bad++; $display("FAIL bez_off got=%h exp=fff", br_offset); end
    cyc();
    total++; if (br_valid !== 1'b0 || br_taken !== 1'b0 || br_offset !== 12'hFFF) begin bad++;
      $display("FAIL bez_after got=%b%b/%h exp=00/fff", br_valid, br_taken, br_offset); end
    // BNEZ ra=1 (r1=5)
    issue(mk(8'h21, 4'd0, 4'd1, 16'hFFF0));
    total++; if (alu_a !== 16'd5) begin bad++; $display("FAIL bnez_a got=%h exp=0005", alu_a); end
    alu_y = 16'h0005;
    cyc();
    cyc();
    total++; if ({br_valid, br_taken, wb_valid, illegal} !== 4'b1100) begin bad++;
      $display("FAIL bnez_pulse got=%b exp=1100", {br_valid, br_taken, wb_valid, illegal}); end
    // BEQ ra=1 rb=2, result nonzero -> not taken
    issue(mk(8'h22, 4'd0, 4'd1, 16'h1232));
    total++; if (alu_a !== 16'd5 || alu_b !== 16'd3) begin bad++;
      $display("FAIL beq_ops got=%h/%h exp=0005/0003", alu_a, alu_b); end
    alu_y = 16'h0006;
    cyc();
    cyc();
    total++; if ({br_valid, br_taken, wb_valid, illegal} !== 4'b1000) begin bad++;
      $display("FAIL beq_pulse got=%b exp=1000", {br_valid, br_taken, wb_valid, illegal}); end
    total++; if (br_offset !== 12'h123) begin bad++; $display("FAIL beq_off got=%h exp=123", br_offset); end
    total++; if (wb_addr !== 4'd0 || wb_data !== 16'h0077) begin bad++;
      $display("FAIL beq_wbhold got=%h/%h exp=0/0077", wb_addr, wb_data); end
  endtask

  task automatic test_back_to_back();
    instr_valid = 1'b1;
    instr       = mk(8'h11, 4'd5, 4'd0, 16'h0011);
    cyc();  // A accepted, EXEC
    total++; if (instr_ready !== 1'b0 || alu_b !== 16'h0011) begin bad++;
      $display("FAIL b2b_exec got=%b/%h exp=0/0011", instr_ready, alu_b); end
    instr = mk(8'h11, 4'd6, 4'd5, 16'h0001);
    alu_y = 16'h0011;
    cyc();  // WB
    total++; if (instr_ready !== 1'b0 || alu_b !== 16'h0011) begin bad++;
      $display("FAIL b2b_wb got=%b/%h exp=0/0011", instr_ready, alu_b); end
    cyc();  // IDLE with pulse
    total++; if (instr_ready !== 1'b1 || wb_valid !== 1'b1 || wb_addr !== 4'd5) begin bad++;
      $display("FAIL b2b_idle got=%b/%b/%h exp=1/1/5", instr_ready, wb_valid, wb_addr); end
    cyc();  // B accepted 3 cycles after A
    instr_valid = 1'b0;
    total++; if (instr_ready !== 1'b0 || alu_a !== 16'h0011 || alu_b !== 16'h0001) begin bad++;
      $display("FAIL b2b_second got=%b/%h/%h exp=0/0011/0001", instr_ready, alu_a, alu_b); end
    alu_y = 16'h0012;
    cyc();
    cyc();
    dbg_addr = 4'd6;
    #1;
    total++; if (wb_valid !== 1'b1 || wb_addr !== 4'd6 || dbg_data !== 16'h0012) begin bad++;
      $display("FAIL b2b_wb2 got=%b/%h/%h exp=1/6/0012", wb_valid, wb_addr, dbg_data); end
  endtask

  task automatic test_nop_illegal();
    issue(mk(8'h00, 4'd1, 4'd1, 16'h0000));
    alu_y = 'x;
    cyc();
    cyc();
    dbg_addr = 4'd1;
    #1;
    total++; if ({wb_valid, br_valid, illegal} !== 3'b000) begin bad++;
      $display("FAIL nop_pulses got=%b exp=000", {wb_valid, br_valid, illegal}); end
    total++; if (dbg_data !== 16'h0005 || wb_data !== 16'h0012) begin bad++;
      $display("FAIL nop_regs got=%h/%h exp=0005/0012", dbg_data, wb_data); end
    issue(mk(8'hFE, 4'd2, 4'd1, 16'h0000));
    cyc();
    cyc();
    dbg_addr = 4'd2;
    #1;
    total++; if ({illegal, wb_valid, br_valid} !== 3'b100) begin bad++;
      $display("FAIL ill_pulse got=%b exp=100", {illegal, wb_valid, br_valid}); end
    total++; if (dbg_data !== 16'h0003) begin bad++; $display("FAIL ill_r2 got=%h exp=0003", dbg_data); end
    cyc();
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill_clear got=%b exp=0", illegal); end
    alu_y = '0;
  endtask

  task automatic test_reset_mid();
    issue(mk(8'h11, 4'd4, 4'd0, 16'h0009));
    total++; if (alu_b !== 16'h0009) begin bad++; $display("FAIL rmid_b got=%h exp=0009", alu_b); end
    alu_y = 16'h0009;
    rst   = 1'b1;
    #1;
    total++; if ({alu_opcode, alu_a, alu_b, alu_shift} !== 45'h0) begin bad++;
      $display("FAIL rmid_alu got=%h exp=0", {alu_opcode, alu_a, alu_b, alu_shift}); end
    total++; if ({wb_addr, wb_data, br_offset} !== 32'h0) begin bad++;
      $display("FAIL rmid_outs got=%h exp=0", {wb_addr, wb_data, br_offset}); end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    total++; if (instr_ready !== 1'b1 || wb_valid !== 1'b0) begin bad++;
      $display("FAIL rmid_ready got=%b/%b exp=1/0", instr_ready, wb_valid); end
    cyc();
    dbg_addr = 4'd4;
    #1;
    total++; if (wb_valid !== 1'b0 || dbg_data !== 16'h0) begin bad++;
      $display("FAIL rmid_r4 got=%b/%h exp=0/0000", wb_valid, dbg_data); end
    dbg_addr = 4'd1;
    #1;
    total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL rmid_r1 got=%h exp=0000", dbg_data); end
  endtask

  initial begin
    test_reset();
    test_imm_writeback();
    test_reg_operands();
    test_r0_write();
    test_branches();
    test_back_to_back();
    test_nop_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
